// File: rtl/spram_seq_pkg.sv
// rtl/spram_seq_pkg.sv - shared state, size encoding and defaults for the byte-sequencing arbiter
package spram_seq_pkg;

  localparam int AW_DEF = 17;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, ACK} state_t;

  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;

  // Encoding 3 is treated as a full word.
  function automatic logic [2:0] sz_bytes(input logic [1:0] sz);
    case (sz)
      SZ_1B:   return 3'd1;
      SZ_2B:   return 3'd2;
      SZ_4B:   return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational NREQ-way round-robin picker, searching upward from ptr+1
module rr_arb #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    jj  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      jj = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/spram8_seq_arb.sv
// rtl/spram8_seq_arb.sv - shares one byte-wide single-port memory between NREQ requesters,
// sequencing 1/2/4-byte little-endian accesses one byte per cycle
module spram8_seq_arb
  import spram_seq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = AW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ-1:0][1:0]      sz,
  input  logic [NREQ-1:0][AW-1:0]   ai,
  input  logic [NREQ-1:0][31:0]     vi,
  output logic [NREQ-1:0]           ack,
  output logic [31:0]               vo,
  output logic                      mem_we,
  output logic [AW-1:0]             mem_ai,
  output logic [7:0]                mem_vi,
  input  logic [7:0]                mem_vo
);

  localparam int IW = $clog2(NREQ);

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n, pick;
  logic [NREQ-1:0] gnt, win_oh, win_oh_n, ack_n;
  logic            any;
  logic            l_we, l_we_n;
  logic [2:0]      l_n, l_n_n;
  logic [AW-1:0]   l_ai, l_ai_n;
  logic [31:0]     l_vi, l_vi_n;
  logic [1:0]      k, k_n, lastb;
  logic [31:0]     res, res_n, vo_n;
  logic            mem_we_n;
  logic [AW-1:0]   mem_ai_n;
  logic [7:0]      mem_vi_n;

  rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (pick),
    .any (any)
  );

  assign lastb = 2'(l_n - 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= IW'(NREQ - 1);
      win_oh <= '0;
      l_we   <= 1'b0;
      l_n    <= 3'd1;
      l_ai   <= '0;
      l_vi   <= '0;
      k      <= '0;
      res    <= '0;
      ack    <= '0;
      vo     <= '0;
      mem_we <= 1'b0;
      mem_ai <= '0;
      mem_vi <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      win_oh <= win_oh_n;
      l_we   <= l_we_n;
      l_n    <= l_n_n;
      l_ai   <= l_ai_n;
      l_vi   <= l_vi_n;
      k      <= k_n;
      res    <= res_n;
      ack    <= ack_n;
      vo     <= vo_n;
      mem_we <= mem_we_n;
      mem_ai <= mem_ai_n;
      mem_vi <= mem_vi_n;
    end
  end

  // Memory-bus outputs are computed one state ahead so that byte k is on the bus during ISSUE cycle k.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    win_oh_n = win_oh;
    l_we_n   = l_we;
    l_n_n    = l_n;
    l_ai_n   = l_ai;
    l_vi_n   = l_vi;
    k_n      = k;
    res_n    = res;
    ack_n    = '0;
    vo_n     = '0;
    mem_we_n = 1'b0;
    mem_ai_n = mem_ai;
    mem_vi_n = mem_vi;
    case (state)
      IDLE: begin
        if (any) begin
          state_n  = ISSUE;
          ptr_n    = pick;
          win_oh_n = gnt;
          l_we_n   = we[pick];
          l_n_n    = sz_bytes(sz[pick]);
          l_ai_n   = ai[pick];
          l_vi_n   = vi[pick];
          k_n      = 2'd0;
          res_n    = '0;
          mem_we_n = we[pick];
          mem_ai_n = ai[pick];
          mem_vi_n = vi[pick][7:0];
        end
      end
      ISSUE: begin
        if (!l_we && k != 2'd0)
          res_n = res | ({24'd0, mem_vo} << {k - 2'd1, 3'b000});
        if ({1'b0, k} == l_n - 3'd1) begin
          state_n = DRAIN;
        end else begin
          k_n      = k + 2'd1;
          mem_we_n = l_we;
          mem_ai_n = l_ai + AW'(k_n);
          mem_vi_n = l_vi[{k_n, 3'b000} +: 8];
        end
      end
      DRAIN: begin
        if (!l_we)
          res_n = res | ({24'd0, mem_vo} << {lastb, 3'b000});
        ack_n   = win_oh;
        vo_n    = res_n;
        state_n = ACK;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spram8_seq_arb.sv
// tb/tb_spram8_seq_arb.sv - directed and randomized bench for spram8_seq_arb against a timeline model
module tb_spram8_seq_arb;

  localparam int NREQ = 2;
  localparam int AW   = 17;
  localparam int MSZ  = 1 << AW;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NREQ-1:0]         req, we;
  logic [NREQ-1:0][1:0]    sz;
  logic [NREQ-1:0][AW-1:0] ai;
  logic [NREQ-1:0][31:0]   vi;
  logic [NREQ-1:0]         ack;
  logic [31:0]             vo;
  logic                    mem_we;
  logic [AW-1:0]           mem_ai;
  logic [7:0]              mem_vi;
  logic [7:0]              mem_vo;

  always #5 clk = ~clk;

  spram8_seq_arb #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .sz(sz), .ai(ai), .vi(vi),
    .ack(ack), .vo(vo), .mem_we(mem_we), .mem_ai(mem_ai), .mem_vi(mem_vi), .mem_vo(mem_vo)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 7));
  endfunction

  // Byte memory with one-cycle registered read (read-before-write).
  logic [7:0] ram [MSZ];
  initial begin
    for (int a = 0; a < MSZ; a++) ram[a] = init_byte(a);
    mem_vo <= 8'h00;
    forever begin
      @(posedge clk);
      mem_vo <= ram[mem_ai];
      if (mem_we) ram[mem_ai] = mem_vi;
    end
  end

  typedef struct {
    logic [NREQ-1:0] ack;
    logic            we;
    logic            chk_addr;
    logic [AW-1:0]   addr;
    logic            chk_vi;
    logic [7:0]      data;
    logic            chk_vo;
    logic [31:0]     vo;
  } exp_t;

  typedef struct {
    int            agent;
    logic          we;
    logic [1:0]    sz;
    logic [AW-1:0] ai;
    logic [31:0]   vi;
  } txn_t;

  exp_t       exp_tab [int];
  logic [7:0] shadow [MSZ];
  txn_t       pend [$];
  bit         active [NREQ];
  int         ack_at [NREQ];
  int         m_ptr, next_sample, cyc, rst_at;
  bit         force_rst, arm_rst, eager;
  int         checks, failures;
  int         ack_idx_log [$];
  int         ack_t_log [$];
  int         load_log [$];
  logic [31:0]   vo_log [$];
  logic [AW-1:0] wa_log [$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, want);
    end
  endtask

  task automatic clear_logs();
    ack_idx_log.delete(); ack_t_log.delete(); load_log.delete(); vo_log.delete(); wa_log.delete();
  endtask

  task automatic compare();
    exp_t e;
    e = '{default: '0};
    if (exp_tab.exists(cyc)) e = exp_tab[cyc];
    chk("ack", 32'(ack), 32'(e.ack));
    chk("mem_we", 32'(mem_we), 32'(e.we));
    if (e.chk_addr) chk("mem_ai", 32'(mem_ai), 32'(e.addr));
    if (e.chk_vi) chk("mem_vi", 32'(mem_vi), 32'(e.data));
    if (e.chk_vo) chk("vo", vo, e.vo);
    if (ack != '0) begin
      ack_idx_log.push_back(ack[1] ? 1 : 0);
      ack_t_log.push_back(cyc);
      vo_log.push_back(vo);
    end
    if (mem_we) wa_log.push_back(mem_ai);
  endtask

  task automatic agents_step();
    for (int i = 0; i < NREQ; i++) begin
      if (active[i] && ack_at[i] == cyc) begin
        active[i] = 1'b0;
        req[i]    = 1'b0;
      end
      if (!active[i]) begin
        int idx;
        idx = -1;
        foreach (pend[q]) if (idx < 0 && pend[q].agent == i) idx = q;
        if (idx >= 0 && (eager || $urandom_range(0, 1) == 1)) begin
          req[i] = 1'b1;
          we[i]  = pend[idx].we;
          sz[i]  = pend[idx].sz;
          ai[i]  = pend[idx].ai;
          vi[i]  = pend[idx].vi;
          pend.delete(idx);
          active[i] = 1'b1;
          ack_at[i] = -1;
          load_log.push_back(cyc + 1);
        end else begin
          req[i] = 1'b0;
          we[i]  = 1'($urandom);
          sz[i]  = 2'($urandom);
          ai[i]  = AW'($urandom);
          vi[i]  = $urandom;
        end
      end
    end
  endtask

  // Advances the model over clock edge p: a transfer sampled at p shows byte k after edge p+k
  // and its ack after edge p+n+1; the next request can be sampled at p+n+3.
  task automatic model_edge(input int p);
    int w, n, a;
    logic [31:0] rd;
    int keys [$];
    if (exp_tab.exists(p - 1) && exp_tab[p - 1].we) shadow[exp_tab[p - 1].addr] = exp_tab[p - 1].data;
    if (rst) begin
      foreach (exp_tab[key]) if (key >= p) keys.push_back(key);
      foreach (keys[i]) exp_tab.delete(keys[i]);
      m_ptr       = NREQ - 1;
      next_sample = p + 1;
      for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
    end else if (p >= next_sample && req != '0) begin
      w = -1;
      for (int i = 1; i <= NREQ; i++) begin
        int j;
        j = (m_ptr + i) % NREQ;
        if (w < 0 && req[j]) w = j;
      end
      n  = (sz[w] == 2'd0) ? 1 : (sz[w] == 2'd1) ? 2 : 4;
      rd = '0;
      for (int k = 0; k < n; k++) begin
        a = (int'(ai[w]) + k) % MSZ;
        exp_tab[p + k] = '{ack: '0, we: we[w], chk_addr: 1'b1, addr: AW'(a), chk_vi: we[w],
                           data: vi[w][8*k +: 8], chk_vo: 1'b0, vo: '0};
        if (!we[w]) rd[8*k +: 8] = shadow[a];
      end
      exp_tab[p + n + 1] = '{ack: NREQ'(1 << w), we: 1'b0, chk_addr: 1'b0, addr: '0, chk_vi: 1'b0,
                             data: '0, chk_vo: 1'b1, vo: rd};
      ack_at[w]   = p + n + 1;
      next_sample = p + n + 3;
      m_ptr       = w;
      if (arm_rst && we[w]) begin
        rst_at  = p + 2;
        arm_rst = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    agents_step();
    rst = force_rst || (cyc + 1 == rst_at);
    model_edge(cyc + 1);
    cyc++;
  endtask

  task automatic do_reset();
    force_rst = 1'b1;
    repeat (3) step();
    force_rst = 1'b0;
  endtask

  function automatic bit busy();
    bit b;
    b = pend.size() != 0 || cyc < next_sample + 1;
    for (int i = 0; i < NREQ; i++) b = b || active[i];
    return b;
  endfunction

  task automatic run_quiet(input int budget);
    int t;
    t = 0;
    while (busy() && t < budget) begin
      step();
      t++;
    end
    if (t >= budget) begin
      checks++;
      failures++;
      $display("FAIL quiet_timeout cyc=%0d got=busy exp=idle", cyc);
    end
    repeat (2) step();
  endtask

  task automatic push(input int ag, input logic w, input logic [1:0] s, input int a, input logic [31:0] v);
    txn_t t;
    t = '{agent: ag, we: w, sz: s, ai: AW'(a), vi: v};
    pend.push_back(t);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    int ord [6];
    int wrap [4];
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; force_rst = 1'b1; rst_at = -100; arm_rst = 1'b0; eager = 1'b1;
    req = '0; we = '0; sz = '0; ai = '0; vi = '0;
    m_ptr = NREQ - 1; next_sample = 0;
    for (int i = 0; i < NREQ; i++) begin active[i] = 1'b0; ack_at[i] = -1; end
    for (int a = 0; a < MSZ; a++) shadow[a] = init_byte(a);

    // Reset then idle: all outputs at their reset values.
    do_reset();
    for (int t = 0; t < 6; t++)
      exp_tab[cyc + t] = '{ack: '0, we: 1'b0, chk_addr: 1'b1, addr: '0, chk_vi: 1'b1,
                           data: '0, chk_vo: 1'b1, vo: '0};
    repeat (6) step();

    // Word write then read back by requester 0.
    clear_logs();
    push(0, 1'b1, 2'd2, 'h00100, 32'hDDCCBBAA);
    push(0, 1'b0, 2'd2, 'h00100, 32'h0);
    run_quiet(100);
    chk("wr_bytes", 32'(wa_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_log.size(); i++) chk("wr_addr", 32'(wa_log[i]), 32'h100 + 32'(i));
    chk("b_acks", 32'(ack_idx_log.size()), 32'd2);
    if (ack_idx_log.size() == 2) begin
      chk("b_wr_lat", 32'(ack_t_log[0] - load_log[0]), 32'd5);
      chk("b_rd_vo", vo_log[1], 32'hDDCCBBAA);
      chk("b_rd_gap", 32'(ack_t_log[1] - ack_t_log[0]), 32'd7);
    end

    // Byte and halfword reads by requester 1.
    clear_logs();
    push(1, 1'b0, 2'd0, 'h00101, 32'hFFFFFFFF);
    push(1, 1'b0, 2'd1, 'h00102, 32'hFFFFFFFF);
    run_quiet(100);
    chk("c_acks", 32'(ack_idx_log.size()), 32'd2);
    if (ack_idx_log.size() == 2) begin
      chk("c_byte_vo", vo_log[0], 32'h000000BB);
      chk("c_byte_lat", 32'(ack_t_log[0] - load_log[0]), 32'd2);
      chk("c_half_vo", vo_log[1], 32'h0000DDCC);
    end

    // Both requesters held high after reset: strict alternation starting at 0.
    do_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 2'($urandom), int'($urandom_range(0, MSZ - 1)), 32'h0);
      push(1, 1'b0, 2'($urandom), int'($urandom_range(0, MSZ - 1)), 32'h0);
    end
    run_quiet(200);
    ord = '{0, 1, 0, 1, 0, 1};
    chk("d_acks", 32'(ack_idx_log.size()), 32'd6);
    for (int i = 0; i < 6 && i < ack_idx_log.size(); i++) chk("d_order", 32'(ack_idx_log[i]), 32'(ord[i]));

    // Address wrap at the top of memory.
    clear_logs();
    push(0, 1'b1, 2'd2, 'h1FFFE, 32'h44332211);
    push(0, 1'b0, 2'd2, 'h1FFFE, 32'h0);
    run_quiet(100);
    wrap = '{'h1FFFE, 'h1FFFF, 'h00000, 'h00001};
    chk("e_wr_bytes", 32'(wa_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa_log.size(); i++) chk("e_wrap_addr", 32'(wa_log[i]), 32'(wrap[i]));
    if (vo_log.size() == 2) chk("e_rd_vo", vo_log[1], 32'h44332211);
    else chk("e_acks", 32'(vo_log.size()), 32'd2);

    // Reset during the second byte of a word write: only two bytes land, no ack for the write.
    push(0, 1'b1, 2'd2, 'h00200, 32'h00000000);
    run_quiet(100);
    clear_logs();
    arm_rst = 1'b1;
    push(0, 1'b1, 2'd2, 'h00200, 32'h88776655);
    push(0, 1'b0, 2'd2, 'h00200, 32'h0);
    run_quiet(100);
    chk("f_wr_bytes", 32'(wa_log.size()), 32'd2);
    chk("f_acks", 32'(ack_idx_log.size()), 32'd1);
    if (vo_log.size() == 1) chk("f_rd_vo", vo_log[0], 32'h00006655);

    // Randomized traffic around the wrap point with random request timing.
    eager = 1'b0;
    for (int i = 0; i < 60; i++)
      push(int'($urandom_range(0, NREQ - 1)), 1'($urandom), 2'($urandom),
           (32'h1FFFC + $urandom_range(0, 11)) % MSZ, $urandom);
    run_quiet(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
